gray_ptr_sync: RTL and testbench
================================

GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchroniser flops (legal range 2..3).
REQ-002 clk  input  1  SHALL be the sole clock; all flops SHALL be rising-edge clk.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 gray_in  input  4  SHALL carry a 4-bit Gray-coded pointer from a foreign clock domain, treated as asynchronous.
REQ-005 err_clr  input  1  SHALL be a synchronous clear for err_sticky.
REQ-006 gray_sync  output  4  SHALL be the synchronised Gray value (last synchroniser stage).
REQ-007 bin_out  output  4  SHALL be the registered binary equivalent of the last accepted gray_sync.
REQ-008 step_valid  output  1  SHALL be a one-cycle pulse marking a legal single-step update of bin_out.
REQ-009 dir  output  1  SHALL give the direction of the last legal step (1 = +1, 0 = -1), held until the next legal step.
REQ-010 step_err  output  1  SHALL be a one-cycle pulse marking an illegal (multi-bit) Gray change.
REQ-011 err_sticky  output  1  SHALL stay high from any step_err until cleared.

Function
REQ-012 gray_in SHALL pass through SYNC_STAGES flops; gray_sync SHALL equal the last stage.
REQ-013 Change detection SHALL compare gray_sync with an internal prev_gray register each cycle.
REQ-014 Latency: gray_in stable before edge k SHALL appear on gray_sync after edge k+SYNC_STAGES-1 and on bin_out/step_valid/step_err after edge k+SYNC_STAGES.
REQ-015 If gray_sync == prev_gray, all outputs SHALL hold and no pulses SHALL fire.
REQ-016 If gray_sync differs from prev_gray in exactly one bit, the block SHALL load prev_gray <= gray_sync and bin_out <= gray_to_bin(gray_sync), and pulse step_valid.
REQ-017 On a legal step, dir SHALL be 1 if new binary == (old binary + 1) mod 16, else 0; wrap 15->0 SHALL give dir=1, and 0->15 SHALL give dir=0.
REQ-018 If gray_sync differs in two or more bits, the block SHALL pulse step_err, set err_sticky, and still load prev_gray and bin_out with the new value; step_valid SHALL stay 0 and dir SHALL hold.
REQ-019 step_valid and step_err SHALL never be high in the same cycle.
REQ-020 The first change after reset (primed flag = 0) SHALL load prev_gray/bin_out and set primed without firing step_valid or step_err, whatever the Hamming distance.
REQ-021 err_clr SHALL clear err_sticky on the next edge; if step_err fires in the same cycle, set SHALL win.
REQ-022 Binary conversion SHALL be B[3]=G[3], B[i]=B[i+1]^G[i] for i=2..0.

Reset
REQ-023 While rst_n=0, all synchroniser stages, prev_gray, gray_sync, bin_out, dir, step_valid, step_err, err_sticky and primed SHALL be 0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard in-flight synchroniser contents; after release, operation SHALL resume per REQ-020.

Structure
REQ-025 A shared package SHALL hold PTR_W = 4 and the default SYNC_STAGES constant.
REQ-026 Combinational conversion SHALL live in one sub-module, gray_to_bin (4-bit in, 4-bit out); this block SHALL contain no other sub-modules.

Verification
REQ-027 Reset, then gray_in=0000 held -> all outputs 0, no pulses.
REQ-028 After priming, drive gray_in through the Gray sequence of bin 0..15 and back to 0 with 4-cycle holds -> each step gives one step_valid pulse 2 cycles after gray_in changes (SYNC_STAGES=2), bin_out increments, dir=1, and the 1000->0000 wrap gives bin_out=0 and dir=1.
REQ-029 From bin_out=5 (gray 0111), drive gray 0101 -> bin_out=6, dir=1; then drive 0111 -> bin_out=5, dir=0.
REQ-030 From gray 0000 (primed), jump to 0011 -> step_err pulse, err_sticky=1, bin_out=2, step_valid=0; then err_clr=1 -> err_sticky=0 next cycle.
REQ-031 Hold gray_in=0110 across reset release -> the first update gives bin_out=4 with no step_valid and no step_err.
REQ-032 Assert rst_n=0 mid-sequence between clk edges -> outputs 0 immediately; err_clr and step_err in the same cycle -> err_sticky=1.

Source files
------------

// File: rtl/gray_ptr_sync_pkg.sv
// Shared constants and helpers for the Gray pointer synchroniser.
// Classifies a Gray change by its Hamming distance.
package gray_ptr_sync_pkg;

  localparam int PTR_W           = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    CHG_NONE = 2'd0,
    CHG_STEP = 2'd1,
    CHG_JUMP = 2'd2
  } chg_e;

  // A legal Gray update flips exactly one bit; two or more is a jump.
  function automatic chg_e classify_change(input logic [PTR_W-1:0] cur,
                                           input logic [PTR_W-1:0] prev);
    logic [PTR_W-1:0] diff;
    diff = cur ^ prev;
    if (diff == '0) return CHG_NONE;
    if ((diff & (diff - 1'b1)) == '0) return CHG_STEP;
    return CHG_JUMP;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_gray_to_bin.sv
// Combinational Gray-to-binary conversion: MSB copies through, each
// lower bit is the running XOR of the Gray bits above and including it.
module gray_to_bin
  import gray_ptr_sync_pkg::*;
(
  input  logic [PTR_W-1:0] gray,
  output logic [PTR_W-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[PTR_W-1] = gray[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_ptr_sync.sv
// Synchronises a foreign-domain Gray pointer, converts it to binary and
// flags legal single steps (with direction) versus illegal multi-bit jumps.
module gray_ptr_sync
  import gray_ptr_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF  // legal range 2..3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PTR_W-1:0] gray_in,
  input  logic             err_clr,
  output logic [PTR_W-1:0] gray_sync,
  output logic [PTR_W-1:0] bin_out,
  output logic             step_valid,
  output logic             dir,
  output logic             step_err,
  output logic             err_sticky
);

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] prev_gray;
  logic [PTR_W-1:0] bin_next;
  logic             primed;
  logic             dir_up;
  chg_e             chg;

  // Plain flop chain; only stage 0 sees the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gray_sync = sync_q[SYNC_STAGES-1];

  gray_to_bin u_gray_to_bin (
    .gray (gray_sync),
    .bin  (bin_next)
  );

  always_comb begin
    chg    = classify_change(gray_sync, prev_gray);
    dir_up = (bin_next == bin_out + PTR_W'(1));
  end

  // Every change reloads the pointer; pulses only fire once primed, so the
  // first value seen after reset is adopted silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray  <= '0;
      bin_out    <= '0;
      primed     <= 1'b0;
      dir        <= 1'b0;
      step_valid <= 1'b0;
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      step_err   <= 1'b0;
      if (chg != CHG_NONE) begin
        prev_gray <= gray_sync;
        bin_out   <= bin_next;
        primed    <= 1'b1;
        if (primed && chg == CHG_STEP) begin
          step_valid <= 1'b1;
          dir        <= dir_up;
        end
        if (primed && chg == CHG_JUMP) step_err <= 1'b1;
      end
      // Set has priority over a simultaneous clear.
      if (primed && chg == CHG_JUMP) err_sticky <= 1'b1;
      else if (err_clr)              err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: directed scenarios plus randomized traffic,
// compared cycle by cycle against a table-driven behavioural model.
module tb_gray_ptr_sync;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] gray_in = 4'd0;
  logic       err_clr = 1'b0;
  logic [3:0] gray_sync;
  logic [3:0] bin_out;
  logic       step_valid;
  logic       dir;
  logic       step_err;
  logic       err_sticky;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];

  gray_ptr_sync #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .gray_sync  (gray_sync),
    .bin_out    (bin_out),
    .step_valid (step_valid),
    .dir        (dir),
    .step_err   (step_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] gray_of(input int b);
    return 4'((b ^ (b >> 1)) & 15);
  endfunction

  function automatic logic [3:0] bin_of(input logic [3:0] g);
    for (int b = 0; b < 16; b++) if (gray_of(b) == g) return 4'(b);
    return 4'd0;
  endfunction

  logic [3:0] m_pipe [SYNC];
  logic [3:0] m_prev = 4'd0;
  logic [3:0] m_bin = 4'd0;
  logic       m_primed = 1'b0, m_sv = 1'b0, m_dir = 1'b0, m_se = 1'b0, m_sticky = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 4'd0;
      m_prev = 0; m_bin = 0; m_primed = 0; m_sv = 0; m_dir = 0; m_se = 0; m_sticky = 0;
    end else begin
      logic [3:0] g;
      int nb;
      g = m_pipe[SYNC-1];
      m_sv = 0;
      m_se = 0;
      if (g != m_prev) begin
        nb = int'(bin_of(g));
        if (m_primed) begin
          if ($countones(g ^ m_prev) == 1) begin
            m_sv  = 1;
            m_dir = (nb == ((int'(m_bin) + 1) % 16));
          end else begin
            m_se = 1;
          end
        end
        m_primed = 1;
        m_prev   = g;
        m_bin    = 4'(nb);
      end
      if (m_se) m_sticky = 1;
      else if (err_clr) m_sticky = 0;
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = gray_in;
    end
  end

  function automatic logic [11:0] m_vec();
    return {m_pipe[SYNC-1], m_bin, m_sv, m_dir, m_se, m_sticky};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {gray_sync, bin_out, step_valid, dir, step_err, err_sticky};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hold(input logic [3:0] g, input int n);
    gray_in = g;
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; gray_in = 4'd0; err_clr = 1'b0;
    #3;
    n_cmp++;
    if (dut_vec() !== 12'd0) begin
      n_fail++; $display("FAIL reset_async: got %h exp 000", dut_vec());
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== 12'd0 || m_vec() !== 12'd0) begin
        n_fail++; $display("FAIL reset_idle: got %h model %h exp 000", dut_vec(), m_vec());
      end
    end
  endtask

  task automatic test_prime();
    drive_hold(gray_of(1), 4);
    drive_hold(4'd0, 4);
    n_cmp++;
    if (dut_vec() !== m_vec() || bin_out !== 4'd0) begin
      n_fail++; $display("FAIL prime: got %h model %h", dut_vec(), m_vec());
    end
  endtask

  task automatic test_walk();
    for (int b = 1; b <= 16; b++) begin
      int pulses;
      pulses = 0;
      exp_q.push_back(4'(b % 16));
      gray_in = gray_of(b % 16);
      for (int t = 1; t <= 4; t++) begin
        tick();
        n_cmp++;
        if (dut_vec() !== m_vec()) begin
          n_fail++; $display("FAIL walk_model b=%0d t=%0d: got %h exp %h", b, t, dut_vec(), m_vec());
        end
        if (step_valid === 1'b1) begin
          logic [3:0] e;
          pulses++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
          n_cmp++;
          if (t != SYNC + 1 || bin_out !== e || dir !== 1'b1 || step_err !== 1'b0) begin
            n_fail++;
            $display("FAIL walk_step b=%0d: t=%0d bin=%h dir=%b exp t=%0d bin=%h dir=1",
                     b, t, bin_out, dir, SYNC + 1, e);
          end
        end
      end
      n_cmp++;
      if (pulses != 1) begin
        n_fail++; $display("FAIL walk_pulses b=%0d: got %0d exp 1", b, pulses);
      end
    end
  endtask

  task automatic test_up_down();
    for (int b = 1; b <= 5; b++) drive_hold(gray_of(b), 4);
    drive_hold(4'b0101, 4);
    n_cmp++;
    if (bin_out !== 4'd6 || dir !== 1'b1 || dut_vec() !== m_vec()) begin
      n_fail++; $display("FAIL up_step: bin=%h dir=%b exp bin=6 dir=1", bin_out, dir);
    end
    drive_hold(4'b0111, 4);
    n_cmp++;
    if (bin_out !== 4'd5 || dir !== 1'b0 || dut_vec() !== m_vec()) begin
      n_fail++; $display("FAIL down_step: bin=%h dir=%b exp bin=5 dir=0", bin_out, dir);
    end
  endtask

  task automatic test_err();
    bit saw_err, saw_valid;
    for (int b = 4; b >= 0; b--) drive_hold(gray_of(b), 4);
    saw_err = 0; saw_valid = 0;
    gray_in = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (step_err === 1'b1) saw_err = 1;
      if (step_valid === 1'b1) saw_valid = 1;
    end
    n_cmp++;
    if (!saw_err || saw_valid || bin_out !== 4'd2 || err_sticky !== 1'b1 || dir !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_err: err=%b valid=%b bin=%h sticky=%b dir=%b exp 1 0 2 1 0",
               saw_err, saw_valid, bin_out, err_sticky, dir);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (err_sticky !== 1'b0 || dut_vec() !== m_vec()) begin
      n_fail++; $display("FAIL err_clr: sticky=%b exp 0", err_sticky);
    end
  endtask

  task automatic test_wrap_down();
    bit saw_valid;
    drive_hold(gray_of(1), 4);
    drive_hold(gray_of(0), 4);
    saw_valid = 0;
    gray_in = 4'b1000;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (step_valid === 1'b1) saw_valid = 1;
    end
    n_cmp++;
    if (!saw_valid || bin_out !== 4'd15 || dir !== 1'b0) begin
      n_fail++; $display("FAIL wrap_0_to_15: valid=%b bin=%h dir=%b exp 1 f 0", saw_valid, bin_out, dir);
    end
    drive_hold(4'b0000, 4);
    n_cmp++;
    if (bin_out !== 4'd0 || dir !== 1'b1) begin
      n_fail++; $display("FAIL wrap_15_to_0: bin=%h dir=%b exp 0 1", bin_out, dir);
    end
  endtask

  task automatic test_reset_primed();
    bit saw_pulse;
    saw_pulse = 0;
    gray_in = 4'b0110;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (step_valid === 1'b1 || step_err === 1'b1) saw_pulse = 1;
      n_cmp++;
      if (dut_vec() !== m_vec()) begin
        n_fail++; $display("FAIL reprime_model t=%0d: got %h exp %h", t, dut_vec(), m_vec());
      end
    end
    n_cmp++;
    if (saw_pulse || bin_out !== 4'd4 || gray_sync !== 4'b0110) begin
      n_fail++; $display("FAIL reprime: pulse=%b bin=%h exp pulse=0 bin=4", saw_pulse, bin_out);
    end
  endtask

  task automatic test_mid_reset();
    gray_in = gray_of(5);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 12'd0) begin
      n_fail++; $display("FAIL mid_reset: got %h exp 000", dut_vec());
    end
    tick();
    rst_n = 1'b1;
    drive_hold(gray_of(5), 4);
    n_cmp++;
    if (bin_out !== 4'd5 || dut_vec() !== m_vec()) begin
      n_fail++; $display("FAIL mid_reset_resume: got %h exp %h", dut_vec(), m_vec());
    end
    gray_in = gray_of(5) ^ 4'b1010;
    err_clr = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== m_vec()) begin
        n_fail++; $display("FAIL collide_model t=%0d: got %h exp %h", t, dut_vec(), m_vec());
      end
      if (t == SYNC + 1) begin
        n_cmp++;
        if (step_err !== 1'b1 || err_sticky !== 1'b1) begin
          n_fail++; $display("FAIL set_wins: err=%b sticky=%b exp 1 1", step_err, err_sticky);
        end
      end
    end
    n_cmp++;
    if (err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL collide_clear: sticky=%b exp 0", err_sticky);
    end
    err_clr = 1'b0;
  endtask

  task automatic test_random();
    int cur;
    cur = int'(bin_out);
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: cur = (cur + 1) % 16;
        1: cur = (cur + 15) % 16;
        2: cur = $urandom_range(0, 15);
        default: ;
      endcase
      gray_in = gray_of(cur);
      repeat ($urandom_range(1, 4)) begin
        err_clr = ($urandom_range(0, 7) == 0);
        tick();
        n_cmp++;
        if (dut_vec() !== m_vec() || (step_valid && step_err)) begin
          n_fail++; $display("FAIL random it=%0d: got %h exp %h", it, dut_vec(), m_vec());
        end
      end
    end
    err_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prime();
    test_walk();
    test_up_down();
    test_err();
    test_wrap_down();
    test_reset_primed();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
